// File: rtl/axil_rd_arbiter_pkg.sv
// Shared definitions for the AXI4-lite read/write arbiters.
// Holds the arbiter FSM state encoding, AXI response codes, fixed sideband
// widths and the round-robin index helper.
package axil_rd_arbiter_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned PROT_W  = 3;
  localparam int unsigned RESP_W  = 2;

  // Arbiter transaction phases; encoding is shared with the write-side arbiter.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } axil_state_e;

  // AXI4-lite response codes.
  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  // Port index reached by stepping 'offset' places past 'last', wrapping at 'count'.
  function automatic int unsigned rr_index(input int unsigned last,
                                           input int unsigned offset,
                                           input int unsigned count);
    return (last + offset) % count;
  endfunction

  // True for the error responses a slave may return.
  function automatic logic resp_is_error(input logic [RESP_W-1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Round-robin priority encoder, purely combinational.
// Ports:
//   req           request vector, one bit per requester
//   last          index of the most recently granted requester
//   grant_valid_c at least one request is present
//   grant_c       one-hot grant
//   grant_idx_c   binary index of the granted requester
// The search starts one place after 'last' and wraps, so the requester that
// was just served has the lowest priority on the next round.
module axil_rr_arbiter
  import axil_rd_arbiter_pkg::*;
#(
  parameter int unsigned S_COUNT = 2,
  localparam int unsigned CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]    req,
  input  logic [CL_S_COUNT-1:0] last,
  output logic                  grant_valid_c,
  output logic [S_COUNT-1:0]    grant_c,
  output logic [CL_S_COUNT-1:0] grant_idx_c
);

  // First requester found walking forward from last+1.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_c       = '0;
    grant_idx_c   = '0;
    for (int unsigned off = 1; off <= S_COUNT; off++) begin
      if (!grant_valid_c && req[CL_S_COUNT'(rr_index(32'(last), off, S_COUNT))]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = CL_S_COUNT'(rr_index(32'(last), off, S_COUNT));
        grant_c[CL_S_COUNT'(rr_index(32'(last), off, S_COUNT))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_rd_arbiter.sv
// AXI4-lite read arbiter: shares one read master port between S_COUNT
// requesters with round-robin arbitration and one read outstanding at a time.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axil_ar*          per-requester read address channels (flattened)
//   s_axil_r*           per-requester read data channels; data/resp replicated,
//                       rvalid only toward the granted requester
//   m_axil_ar*          shared downstream read address channel
//   m_axil_r*           shared downstream read data channel
// s_axil_arready is the only combinational output; everything else is driven
// straight from flops.
module axil_rd_arbiter
  import axil_rd_arbiter_pkg::*;
#(
  parameter int unsigned S_COUNT    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [S_COUNT*PROT_W-1:0]       s_axil_arprot,
  input  logic [S_COUNT-1:0]              s_axil_arvalid,
  output logic [S_COUNT-1:0]              s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [S_COUNT*RESP_W-1:0]       s_axil_rresp,
  output logic [S_COUNT-1:0]              s_axil_rvalid,
  input  logic [S_COUNT-1:0]              s_axil_rready,

  output logic [ADDR_WIDTH-1:0]           m_axil_araddr,
  output logic [PROT_W-1:0]               m_axil_arprot,
  output logic                            m_axil_arvalid,
  input  logic                            m_axil_arready,
  input  logic [DATA_WIDTH-1:0]           m_axil_rdata,
  input  logic [RESP_W-1:0]               m_axil_rresp,
  input  logic                            m_axil_rvalid,
  output logic                            m_axil_rready
);

  axil_state_e state_q;
  axil_state_e state_d;

  logic                    arb_valid_c;
  logic [S_COUNT-1:0]      arb_grant_c;
  logic [CL_S_COUNT-1:0]   arb_idx_c;

  logic [CL_S_COUNT-1:0]   last_q;
  logic [CL_S_COUNT-1:0]   grant_idx_q;
  logic [S_COUNT-1:0]      grant_oh_q;

  logic                    ar_capture_c;
  logic                    r_capture_c;
  logic                    granted_rready_c;
  logic [S_COUNT-1:0]      s_arready_c;

  logic                    m_arvalid_q;
  logic                    m_arvalid_d;
  logic                    m_rready_q;
  logic                    m_rready_d;
  logic [S_COUNT-1:0]      s_rvalid_q;
  logic [S_COUNT-1:0]      s_rvalid_d;

  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [PROT_W-1:0]       arprot_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [RESP_W-1:0]       rresp_q;

  // Round-robin selection among the requesters currently asserting arvalid.
  axil_rr_arbiter #(
    .S_COUNT (S_COUNT)
  ) u_rr (
    .req           (s_axil_arvalid),
    .last          (last_q),
    .grant_valid_c (arb_valid_c),
    .grant_c       (arb_grant_c),
    .grant_idx_c   (arb_idx_c)
  );

  // Only the requester that owns the outstanding read can close the response.
  assign granted_rready_c = s_axil_rready[grant_idx_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_valid_c)      state_d = ST_ADDR;
      ST_ADDR: if (m_axil_arready)   state_d = ST_DATA;
      ST_DATA: if (m_axil_rvalid)    state_d = ST_RESP;
      ST_RESP: if (granted_rready_c) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Output logic: arready plus next values of the registered handshake outputs.
  always_comb begin
    s_arready_c  = '0;
    ar_capture_c = 1'b0;
    r_capture_c  = 1'b0;
    m_arvalid_d  = 1'b0;
    m_rready_d   = 1'b0;
    s_rvalid_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          s_arready_c  = arb_grant_c;
          ar_capture_c = 1'b1;
          m_arvalid_d  = 1'b1;
        end
      end
      ST_ADDR: begin
        // rready rises on the same edge that completes the AR handshake.
        m_arvalid_d = !m_axil_arready;
        m_rready_d  = m_axil_arready;
      end
      ST_DATA: begin
        m_rready_d = !m_axil_rvalid;
        if (m_axil_rvalid) begin
          r_capture_c = 1'b1;
          s_rvalid_d  = grant_oh_q;
        end
      end
      ST_RESP: begin
        if (!granted_rready_c) begin
          s_rvalid_d = grant_oh_q;
        end
      end
      default: begin
        s_rvalid_d = '0;
      end
    endcase
  end

  // Registered outputs, captured request and captured response.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      s_rvalid_q  <= '0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      // Pointing at the last port gives port 0 first priority after reset.
      last_q      <= CL_S_COUNT'(S_COUNT - 1);
    end else begin
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      s_rvalid_q  <= s_rvalid_d;
      if (ar_capture_c) begin
        araddr_q    <= s_axil_araddr[32'(arb_idx_c)*ADDR_WIDTH +: ADDR_WIDTH];
        arprot_q    <= s_axil_arprot[32'(arb_idx_c)*PROT_W +: PROT_W];
        grant_idx_q <= arb_idx_c;
        grant_oh_q  <= arb_grant_c;
        last_q      <= arb_idx_c;
      end
      if (r_capture_c) begin
        rdata_q <= m_axil_rdata;
        rresp_q <= m_axil_rresp;
      end
    end
  end

  assign s_axil_arready = s_arready_c;
  assign s_axil_rvalid  = s_rvalid_q;
  assign s_axil_rdata   = {S_COUNT{rdata_q}};
  assign s_axil_rresp   = {S_COUNT{rresp_q}};

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = m_arvalid_q;
  assign m_axil_rready  = m_rready_q;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter with four requesters: a cycle
// vector table, directed multi-cycle sequences and a randomized run checked
// against a transaction-level reference model.
module tb_axil_rd_arbiter;
  import axil_rd_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] s_araddr;
  logic [N*3-1:0]  s_arprot;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [N*DW-1:0] s_rdata;
  logic [N*2-1:0]  s_rresp;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready;
  logic [AW-1:0]   m_araddr;
  logic [2:0]      m_arprot;
  logic            m_arvalid;
  logic            m_arready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rvalid;
  logic            m_rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_rd_arbiter #(
    .S_COUNT    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_araddr  (s_araddr),
    .s_axil_arprot  (s_arprot),
    .s_axil_arvalid (s_arvalid),
    .s_axil_arready (s_arready),
    .s_axil_rdata   (s_rdata),
    .s_axil_rresp   (s_rresp),
    .s_axil_rvalid  (s_rvalid),
    .s_axil_rready  (s_rready),
    .m_axil_araddr  (m_araddr),
    .m_axil_arprot  (m_arprot),
    .m_axil_arvalid (m_arvalid),
    .m_axil_arready (m_arready),
    .m_axil_rdata   (m_rdata),
    .m_axil_rresp   (m_rresp),
    .m_axil_rvalid  (m_rvalid),
    .m_axil_rready  (m_rready)
  );

  typedef struct {
    logic [3:0]  arv;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        mar;
    logic        mrv;
    logic [31:0] mrd;
    logic [1:0]  mrs;
    logic [3:0]  srr;
    logic [3:0]  e_arr;
    logic        e_arv;
    logic [31:0] e_addr;
    logic [2:0]  e_prot;
    logic        e_rr;
    logic [3:0]  e_rv;
    logic [31:0] e_rd;
    logic [1:0]  e_rs;
  } vec_t;

  typedef enum {W_REQ, W_AR, W_R, W_ACK} mstage_e;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One call per cycle: lets inputs settle, then compares every visible output.
  task automatic chk_out(input string tag, input logic [3:0] e_arr, input logic e_arv,
                         input logic [31:0] e_addr, input logic [2:0] e_prot,
                         input logic e_rr, input logic [3:0] e_rv,
                         input logic [31:0] e_rd, input logic [1:0] e_rs);
    #2;
    chk($sformatf("%s arready", tag), 64'(s_arready), 64'(e_arr));
    chk($sformatf("%s m_arvalid", tag), 64'(m_arvalid), 64'(e_arv));
    if (e_arv) begin
      chk($sformatf("%s m_araddr", tag), 64'(m_araddr), 64'(e_addr));
      chk($sformatf("%s m_arprot", tag), 64'(m_arprot), 64'(e_prot));
    end
    chk($sformatf("%s m_rready", tag), 64'(m_rready), 64'(e_rr));
    chk($sformatf("%s s_rvalid", tag), 64'(s_rvalid), 64'(e_rv));
    if (e_rv != 4'b0) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s rdata[%0d]", tag, i), 64'(s_rdata[i*DW +: DW]), 64'(e_rd));
        chk($sformatf("%s rresp[%0d]", tag, i), 64'(s_rresp[i*2 +: 2]), 64'(e_rs));
      end
    end
  endtask

  task automatic set_addr(input int port, input logic [31:0] a);
    s_araddr[port*AW +: AW] = a;
  endtask

  task automatic idle_inputs();
    s_arvalid = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = RESP_OKAY;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    chk_out(tag, 4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'b0, 32'h0, 2'b0);
    chk($sformatf("%s m_araddr", tag), 64'(m_araddr), 64'h0);
    chk($sformatf("%s m_arprot", tag), 64'(m_arprot), 64'h0);
    chk($sformatf("%s s_rdata", tag), 64'(s_rdata[DW-1:0]), 64'h0);
    chk($sformatf("%s s_rresp", tag), 64'(s_rresp[1:0]), 64'h0);
    rst = 1'b0;
    next_cycle();
  endtask

  // Full zero-wait transaction; current cycle must be IDLE with arvalid already driven.
  task automatic zw_txn(input string tag, input int port, input logic [31:0] addr,
                        input logic [2:0] prot, input logic [31:0] data, input logic [1:0] resp);
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rdata   = data;
    m_rresp   = resp;
    s_rready  = 4'hF;
    chk_out({tag, " grant"}, 4'(1 << port), 1'b0, 32'h0, 3'd0, 1'b0, 4'b0, 32'h0, 2'b0);
    next_cycle();
    chk_out({tag, " addr"}, 4'b0, 1'b1, addr, prot, 1'b0, 4'b0, 32'h0, 2'b0);
    next_cycle();
    chk_out({tag, " data"}, 4'b0, 1'b0, 32'h0, 3'd0, 1'b1, 4'b0, 32'h0, 2'b0);
    next_cycle();
    chk_out({tag, " resp"}, 4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'(1 << port), data, resp);
    next_cycle();
  endtask

  // Requester closest after 'last' in circular order, by distance arithmetic.
  function automatic int rr_pick(input logic [3:0] req, input int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  initial begin
    #(2_000_000);
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    int   order[7];
    rst      = 1'b1;
    s_araddr = '0;
    s_arprot = {3'd4, 3'd3, 3'd2, 3'd1};
    idle_inputs();

    // Single-port reads with OKAY then SLVERR, one row per cycle.
    tbl[0] = '{4'b0010, 32'h10, 32'h40, 1'b1, 1'b1, 32'hDEADBEEF, RESP_OKAY, 4'hF,
               4'b0010, 1'b0, 32'h0,  3'd0, 1'b0, 4'b0000, 32'h0, 2'b00};
    tbl[1] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'hDEADBEEF, RESP_OKAY, 4'hF,
               4'b0000, 1'b1, 32'h40, 3'd2, 1'b0, 4'b0000, 32'h0, 2'b00};
    tbl[2] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'hDEADBEEF, RESP_OKAY, 4'hF,
               4'b0000, 1'b0, 32'h0,  3'd0, 1'b1, 4'b0000, 32'h0, 2'b00};
    tbl[3] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'hDEADBEEF, RESP_OKAY, 4'hF,
               4'b0000, 1'b0, 32'h0,  3'd0, 1'b0, 4'b0010, 32'hDEADBEEF, RESP_OKAY};
    tbl[4] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'hDEADBEEF, RESP_OKAY, 4'hF,
               4'b0000, 1'b0, 32'h0,  3'd0, 1'b0, 4'b0000, 32'h0, 2'b00};
    tbl[5] = '{4'b0001, 32'h10, 32'h40, 1'b1, 1'b1, 32'h0, RESP_SLVERR, 4'hF,
               4'b0001, 1'b0, 32'h0,  3'd0, 1'b0, 4'b0000, 32'h0, 2'b00};
    tbl[6] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'h0, RESP_SLVERR, 4'hF,
               4'b0000, 1'b1, 32'h10, 3'd1, 1'b0, 4'b0000, 32'h0, 2'b00};
    tbl[7] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'h0, RESP_SLVERR, 4'hF,
               4'b0000, 1'b0, 32'h0,  3'd0, 1'b1, 4'b0000, 32'h0, 2'b00};
    tbl[8] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'h0, RESP_SLVERR, 4'hF,
               4'b0000, 1'b0, 32'h0,  3'd0, 1'b0, 4'b0001, 32'h0, RESP_SLVERR};
    tbl[9] = '{4'b0000, 32'h10, 32'h40, 1'b1, 1'b1, 32'h0, RESP_SLVERR, 4'hF,
               4'b0000, 1'b0, 32'h0,  3'd0, 1'b0, 4'b0000, 32'h0, 2'b00};

    do_reset("reset0");
    for (int i = 0; i < 10; i++) begin
      s_arvalid = tbl[i].arv;
      set_addr(0, tbl[i].a0);
      set_addr(1, tbl[i].a1);
      m_arready = tbl[i].mar;
      m_rvalid  = tbl[i].mrv;
      m_rdata   = tbl[i].mrd;
      m_rresp   = tbl[i].mrs;
      s_rready  = tbl[i].srr;
      chk_out($sformatf("vec%0d", i), tbl[i].e_arr, tbl[i].e_arv, tbl[i].e_addr,
              tbl[i].e_prot, tbl[i].e_rr, tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_rs);
      next_cycle();
    end

    // Contention between ports 0 and 1: strict alternation starting at port 0.
    do_reset("reset1");
    set_addr(0, 32'h10);
    set_addr(1, 32'h20);
    s_arvalid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      zw_txn($sformatf("cont%0d", k), k % 2, (k % 2 == 1) ? 32'h20 : 32'h10,
             3'((k % 2) + 1), 32'hC0DE0000 + 32'(k), RESP_OKAY);
    end
    s_arvalid = '0;

    // Reset while in DATA: everything drops, pointer returns to favour port 0.
    set_addr(0, 32'h70);
    s_arvalid = 4'b0001;
    m_arready = 1'b1;
    m_rvalid  = 1'b0;
    s_rready  = 4'hF;
    chk_out("rst idle", 4'b0001, 1'b0, 32'h0, 3'd0, 1'b0, 4'b0, 32'h0, 2'b0);
    next_cycle();
    s_arvalid = '0;
    chk_out("rst addr", 4'b0, 1'b1, 32'h70, 3'd1, 1'b0, 4'b0, 32'h0, 2'b0);
    next_cycle();
    chk_out("rst data", 4'b0, 1'b0, 32'h0, 3'd0, 1'b1, 4'b0, 32'h0, 2'b0);
    rst      = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'hBAD0BAD0;
    next_cycle();
    rst = 1'b0;
    chk_out("rst after", 4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'b0, 32'h0, 2'b0);
    chk("rst rdata cleared", 64'(s_rdata[DW-1:0]), 64'h0);
    next_cycle();
    s_arvalid = 4'b0011;
    zw_txn("rst first", 0, 32'h70, 3'd1, 32'h600DF00D, RESP_OKAY);
    s_arvalid = '0;

    // Backpressure on both the AR and R sides with a competing requester.
    set_addr(0, 32'h30);
    s_arvalid = 4'b0001;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    s_rready  = 4'hF;
    chk_out("bp grant", 4'b0001, 1'b0, 32'h0, 3'd0, 1'b0, 4'b0, 32'h0, 2'b0);
    next_cycle();
    s_arvalid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("bp ar stall%0d", k), 4'b0, 1'b1, 32'h30, 3'd1, 1'b0, 4'b0, 32'h0, 2'b0);
      next_cycle();
    end
    m_arready = 1'b1;
    chk_out("bp ar go", 4'b0, 1'b1, 32'h30, 3'd1, 1'b0, 4'b0, 32'h0, 2'b0);
    next_cycle();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h5555AAAA;
    m_rresp   = RESP_DECERR;
    s_rready  = 4'b1110;
    chk_out("bp data", 4'b0, 1'b0, 32'h0, 3'd0, 1'b1, 4'b0, 32'h0, 2'b0);
    next_cycle();
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    m_rresp  = RESP_OKAY;
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("bp r stall%0d", k), 4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'b0001,
              32'h5555AAAA, RESP_DECERR);
      next_cycle();
    end
    s_rready = 4'hF;
    chk_out("bp r go", 4'b0, 1'b0, 32'h0, 3'd0, 1'b0, 4'b0001, 32'h5555AAAA, RESP_DECERR);
    next_cycle();
    set_addr(1, 32'h34);
    zw_txn("bp next", 1, 32'h34, 3'd2, 32'h12345678, RESP_OKAY);
    s_arvalid = '0;

    // Four requesters; port 2 withdraws after its first grant.
    do_reset("reset2");
    for (int i = 0; i < N; i++) set_addr(i, 32'(32'h100 * (i + 1)));
    order = '{0, 1, 2, 3, 0, 1, 3};
    s_arvalid = 4'hF;
    for (int k = 0; k < 7; k++) begin
      zw_txn($sformatf("rot%0d", k), order[k], 32'(32'h100 * (order[k] + 1)),
             3'(order[k] + 1), 32'hA0000000 + 32'(k), RESP_OKAY);
      if (order[k] == 2) s_arvalid[2] = 1'b0;
    end
    s_arvalid = '0;

    // Randomized traffic against the transaction-level model.
    do_reset("reset3");
    begin
      mstage_e     stage;
      int          last;
      int          port;
      int          pick;
      logic [31:0] t_addr;
      logic [2:0]  t_prot;
      logic [31:0] t_data;
      logic [1:0]  t_resp;
      logic [3:0]  e_arr;
      stage  = W_REQ;
      last   = N - 1;
      port   = 0;
      t_addr = '0;
      t_prot = '0;
      t_data = '0;
      t_resp = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        s_arvalid = ($urandom % 4 == 0) ? 4'b0 : 4'($urandom);
        for (int i = 0; i < N; i++) set_addr(i, $urandom);
        s_arprot  = 12'($urandom);
        m_arready = ($urandom % 3) != 0;
        m_rvalid  = ($urandom % 3) != 0;
        m_rdata   = $urandom;
        m_rresp   = 2'($urandom);
        s_rready  = 4'($urandom);
        pick  = rr_pick(s_arvalid, last);
        e_arr = (stage == W_REQ && pick >= 0) ? 4'(1 << pick) : 4'b0;
        chk_out($sformatf("rand%0d", cyc), e_arr, stage == W_AR, t_addr, t_prot,
                stage == W_R, (stage == W_ACK) ? 4'(1 << port) : 4'b0, t_data, t_resp);
        case (stage)
          W_REQ: if (pick >= 0) begin
            port   = pick;
            last   = pick;
            t_addr = s_araddr[pick*AW +: AW];
            t_prot = s_arprot[pick*3 +: 3];
            stage  = W_AR;
          end
          W_AR:  if (m_arready) stage = W_R;
          W_R:   if (m_rvalid) begin
            t_data = m_rdata;
            t_resp = m_rresp;
            stage  = W_ACK;
          end
          W_ACK: if (s_rready[port]) stage = W_REQ;
          default: stage = W_REQ;
        endcase
        next_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_rd_arbiter.md
Name: axil_rd_arbiter

Overview:
- Shares one AXI4-lite read master port between S_COUNT AXI4-lite read slave ports.
- Arbitration is round-robin, with exactly one read outstanding at a time.
- The R response is registered and returned only to the port that won the grant.
- Sits upstream of an AXI-lite register slice on the read path, so several CSR masters can share a single peripheral read bus.

Parameters:
- S_COUNT, 2, number of slave (requester) ports; range 2..16.
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- CL_S_COUNT, $clog2(S_COUNT), grant index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axil_araddr  in  S_COUNT*ADDR_WIDTH  per-port read address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_axil_arprot  in  S_COUNT*3  per-port protection
- s_axil_arvalid  in  S_COUNT  per-port AR valid
- s_axil_arready  out  S_COUNT  per-port AR ready
- s_axil_rdata  out  S_COUNT*DATA_WIDTH  read data, same value replicated to every port
- s_axil_rresp  out  S_COUNT*2  read response, replicated to every port
- s_axil_rvalid  out  S_COUNT  per-port R valid
- s_axil_rready  in  S_COUNT  per-port R ready
- m_axil_araddr  out  ADDR_WIDTH  shared read address
- m_axil_arprot  out  3  shared protection
- m_axil_arvalid  out  1  AR valid
- m_axil_arready  in  1  AR ready
- m_axil_rdata  in  DATA_WIDTH  read data
- m_axil_rresp  in  2  read response
- m_axil_rvalid  in  1  R valid
- m_axil_rready  out  1  R ready

Interface decisions:
- One clock, clk. rst is synchronous and active-high.

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. Reset sets state=IDLE.
- Reset values:
  - s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready = 0.
  - m_axil_araddr, m_axil_arprot, rdata/rresp holding regs = 0.
  - Last-grant pointer = S_COUNT-1, so port 0 has first priority.
- IDLE:
  - Round-robin select: the first i with s_axil_arvalid[i]=1, searching from (last+1) mod S_COUNT upward with wrap.
  - s_axil_arready[g] is combinational: 1 only in IDLE, only for the winner g, only while a request exists. At most one bit is ever set.
  - On that handshake, capture araddr/arprot/g, update last=g, and go to ADDR.
  - No request: stay in IDLE with all arready=0.
- ADDR:
  - m_axil_arvalid=1 from a register, starting the cycle after the capture.
  - Address and prot stay stable until m_axil_arready=1, then go to DATA.
  - Must tolerate an arbitrarily long m_axil_arready stall.
- DATA:
  - m_axil_rready=1 (registered; asserted the same cycle the AR handshake completes moves state to DATA).
  - On m_axil_rvalid, capture rdata/rresp into registers, drop rready, go to RESP.
- RESP:
  - s_axil_rvalid[g]=1; all other rvalid bits stay 0.
  - rdata/rresp stay stable until s_axil_rready[g]=1, then return to IDLE.
  - Readiness on other ports is ignored.
- Timing:
  - Minimum round trip from s arvalid to s rvalid is 3 cycles, given zero-wait m_arready and m_rvalid.
  - One IDLE cycle separates consecutive transactions.
- Boundary conditions:
  - A port deasserting arvalid while not granted is legal; it is simply not selected.
  - A new arvalid arriving in ADDR/DATA/RESP waits; arready stays 0 outside IDLE.
  - All ports requesting continuously are served in strict rotation 0,1,...,S_COUNT-1,0.
  - A single requester is re-granted every transaction.
  - rresp (including SLVERR/DECERR) is passed through unmodified.
- Reset mid-operation:
  - Immediate return to IDLE and pointer reset; all valid/ready outputs go to 0 on the next edge.
  - Any in-flight response is discarded. Downstream reset must be shared.

Decomposition:
- Shared package/include: state encoding localparams (IDLE=0, ADDR=1, DATA=2, RESP=3) and AXI resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) for reuse by the write-side arbiter.
- Sub-module axil_rr_arbiter: round-robin priority encoder.
  - Inputs: request vector, last-grant index.
  - Outputs: grant_valid, grant one-hot, grant index.
  - Purely combinational, reused by a future axil_wr_arbiter.

Test Plan:
- Single request: port 1 reads 0x0000_0040, slave returns 0xDEADBEEF/OKAY with zero wait → m_araddr=0x40 one cycle after s_arready[1]; s_rvalid[1] 3 cycles after accept with rdata=0xDEADBEEF; s_rvalid[0]=0 throughout.
- Contention: ports 0 and 1 hold arvalid for 4 transactions with addrs 0x10/0x20 → grant order 0,1,0,1; m_araddr sequence 0x10,0x20,0x10,0x20; each response reaches only its requester.
- Backpressure: m_arready held low 5 cycles, then s_rready[0] held low 4 cycles → m_araddr/arvalid stable across the stall; s_rdata/rresp stable and rvalid high until rready; no second arready meanwhile.
- Error pass-through: slave returns rresp=2'b10 with rdata=0x0 → s_rresp of the granted port=2'b10.
- Reset mid-op: assert rst for 1 cycle while in DATA → next cycle all valids/readies 0; first post-reset concurrent request from ports 0 and 1 grants port 0.
- S_COUNT=4, all ports requesting, port 2 drops arvalid after its first grant → rotation 0,1,2,3,0,1,3.
